// File: rtl/rr_arb2_mux_pkg.sv
// rr_arb2_mux_pkg: shared definitions for the two-requester round-robin arbiter.
//   arb_state_e : FSM state encodings (ST_IDLE=0, ST_G0=1, ST_G1=2), also used by
//                 the bench monitor to classify the observed grant.
//   cnt_width() : width of the burst counter, $clog2(n) with a floor of 1 bit.
package rr_arb2_mux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_G0   = 2'd1,
    ST_G1   = 2'd2
  } arb_state_e;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arb_mxw.sv
// arb_mxw: WIDTH-bit 2:1 multiplexer used as the arbiter's shared datapath.
//   d0 : in  WIDTH  selected when s=0
//   d1 : in  WIDTH  selected when s=1
//   s  : in  1      select
//   y  : out WIDTH  selected data
module arb_mxw #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic             s,
  output logic [WIDTH-1:0] y
);

  assign y = s ? d1 : d0;

endmodule

// File: rtl/rr_arb2_mux.sv
// rr_arb2_mux: two-requester round-robin arbiter driving one WIDTH-bit 2:1 mux.
//   clk     : in  1      rising-edge clock
//   reset_n : in  1      synchronous active-low reset
//   req0/1  : in  1      requests, held high until done
//   d0/d1   : in  WIDTH  requester data
//   grant0/1: out 1      registered grants (one-hot or zero)
//   sel     : out 1      registered mux select, equals grant1
//   valid   : out 1      grant0 | grant1
//   y       : out WIDTH  selected data, zero when no grant
// Build option: define ARB_BURST_LIMIT_EN to force a handover after MAX_BURST
// consecutive cycles while the other side is waiting. Without it a grant is
// held until its request drops and MAX_BURST has no effect.
//
// state   | meaning
// ST_IDLE | no grant; ties go to the side that was not served last
// ST_G0   | requester 0 owns the bus
// ST_G1   | requester 1 owns the bus
module rr_arb2_mux
  import rr_arb2_mux_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  output logic             grant0,
  output logic             grant1,
  output logic             sel,
  output logic             valid,
  output logic [WIDTH-1:0] y
);

  arb_state_e       state, state_nxt;
  logic             last;        // 1: requester 1 was granted most recently
  logic             burst_limit; // current owner has used its full burst
  logic [WIDTH-1:0] mux_y;

`ifdef ARB_BURST_LIMIT_EN
  localparam int              CNT_W   = cnt_width(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

  logic [CNT_W-1:0] burst_cnt;

  assign burst_limit = (burst_cnt == CNT_MAX);

  // Cleared on any state change, so entering a grant starts a fresh burst;
  // saturates so a lone requester can hold the bus indefinitely.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      burst_cnt <= '0;
    end else if (state_nxt != state) begin
      burst_cnt <= '0;
    end else if (state_nxt != ST_IDLE && !burst_limit) begin
      burst_cnt <= burst_cnt + 1'b1;
    end
  end
`else
  localparam int max_burst_unused = MAX_BURST;

  assign burst_limit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (req0 && req1)  state_nxt = last ? ST_G0 : ST_G1;
        else if (req0)     state_nxt = ST_G0;
        else if (req1)     state_nxt = ST_G1;
      end
      ST_G0: begin
        if (!req0)                  state_nxt = req1 ? ST_G1 : ST_IDLE;
        else if (req1 && burst_limit) state_nxt = ST_G1;
      end
      ST_G1: begin
        if (!req1)                  state_nxt = req0 ? ST_G0 : ST_IDLE;
        else if (req0 && burst_limit) state_nxt = ST_G0;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state_nxt != state && state_nxt != ST_IDLE) begin
        last <= (state_nxt == ST_G1);
      end
    end
  end

  assign grant0 = (state == ST_G0);
  assign grant1 = (state == ST_G1);
  assign sel    = grant1;
  assign valid  = grant0 | grant1;

  arb_mxw #(.WIDTH(WIDTH)) u_mux (
    .d0 (d0),
    .d1 (d1),
    .s  (sel),
    .y  (mux_y)
  );

  assign y = valid ? mux_y : '0;

endmodule

// File: tb/tb_rr_arb2_mux.sv
// tb_rr_arb2_mux: directed bench for rr_arb2_mux (WIDTH=8, MAX_BURST=4).
// Expectations for contention follow the ARB_BURST_LIMIT_EN build setting.
module tb_rr_arb2_mux;
  import rr_arb2_mux_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req0, req1;
  logic [7:0] d0, d1;
  logic       grant0, grant1, sel, valid;
  logic [7:0] y;

  int tests_run    = 0;
  int tests_failed = 0;
  bit mon_en       = 1'b0;

  always #5 clk = ~clk;

  rr_arb2_mux #(.WIDTH(8), .MAX_BURST(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req0    (req0),
    .req1    (req1),
    .d0      (d0),
    .d1      (d1),
    .grant0  (grant0),
    .grant1  (grant1),
    .sel     (sel),
    .valid   (valid),
    .y       (y)
  );

  // Per-cycle invariants, sampled on the falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      arb_state_e obs_st;
      logic [7:0] y_exp;
      obs_st = grant1 ? ST_G1 : (grant0 ? ST_G0 : ST_IDLE);
      y_exp  = (grant0 | grant1) ? (grant1 ? d1 : d0) : 8'h00;
      tests_run++;
      if ((grant0 & grant1) !== 1'b0) begin
        tests_failed++;
        $display("FAIL mon_onehot t=%0t grant0=%b grant1=%b required not both", $time, grant0, grant1);
      end
      tests_run++;
      if (sel !== (obs_st == ST_G1)) begin
        tests_failed++;
        $display("FAIL mon_sel t=%0t sel=%b required %b", $time, sel, grant1);
      end
      tests_run++;
      if (valid !== (grant0 | grant1)) begin
        tests_failed++;
        $display("FAIL mon_valid t=%0t valid=%b required %b", $time, valid, grant0 | grant1);
      end
      tests_run++;
      if (y !== y_exp) begin
        tests_failed++;
        $display("FAIL mon_y t=%0t y=%h required %h", $time, y, y_exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req0 = 1'b1; req1 = 1'b1; d0 = 8'hAA; d1 = 8'h55;
    for (int i = 0; i < 2; i++) begin
      tick();
      mon_en = 1'b1;
      tests_run++;
      if ({grant0, grant1, valid} !== 3'b000 || y !== 8'h00) begin
        tests_failed++;
        $display("FAIL reset_outputs cyc=%0d g0=%b g1=%b valid=%b y=%h required 0 0 0 00",
                 i, grant0, grant1, valid, y);
      end
    end
  endtask

  task automatic test_single();
    reset_n = 1'b1; req0 = 1'b1; req1 = 1'b0; d0 = 8'hA5; d1 = 8'h5A;
    tick();
    tests_run++;
    if (grant0 !== 1'b1 || sel !== 1'b0 || y !== 8'hA5) begin
      tests_failed++;
      $display("FAIL single_grant g0=%b sel=%b y=%h required 1 0 a5", grant0, sel, y);
    end
    req0 = 1'b0;
    tick();
    tests_run++;
    if (valid !== 1'b0 || y !== 8'h00) begin
      tests_failed++;
      $display("FAIL single_release valid=%b y=%h required 0 00", valid, y);
    end
  endtask

  task automatic test_tie_burst();
    logic [7:0] y_exp;
    reset_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
    tick();
    reset_n = 1'b1; req0 = 1'b1; req1 = 1'b1; d0 = 8'h11; d1 = 8'h22;
    for (int i = 0; i < 16; i++) begin
      tick();
`ifdef ARB_BURST_LIMIT_EN
      y_exp = ((i / 4) % 2 == 1) ? 8'h22 : 8'h11;
`else
      y_exp = 8'h11;
`endif
      tests_run++;
      if (y !== y_exp) begin
        tests_failed++;
        $display("FAIL tie_burst cyc=%0d y=%h required %h", i, y, y_exp);
      end
    end
  endtask

  task automatic test_handover();
    reset_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
    tick();
    reset_n = 1'b1; req0 = 1'b1; d0 = 8'h3C; d1 = 8'hC3;
    tick();
    tests_run++;
    if (grant0 !== 1'b1 || y !== 8'h3C) begin
      tests_failed++;
      $display("FAIL handover_pre g0=%b y=%h required 1 3c", grant0, y);
    end
    req0 = 1'b0; req1 = 1'b1;
    tick();
    tests_run++;
    if (grant1 !== 1'b1 || valid !== 1'b1 || y !== 8'hC3) begin
      tests_failed++;
      $display("FAIL handover_direct g1=%b valid=%b y=%h required 1 1 c3", grant1, valid, y);
    end
  endtask

  task automatic test_last_tie();
    // Last served is requester 1 after the handover test.
    req0 = 1'b0; req1 = 1'b0;
    tick();
    tests_run++;
    if (valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL last_idle1 valid=%b required 0", valid);
    end
    req0 = 1'b1; req1 = 1'b1; d0 = 8'h77; d1 = 8'h88;
    tick();
    tests_run++;
    if (grant0 !== 1'b1 || y !== 8'h77) begin
      tests_failed++;
      $display("FAIL last_tie_g0 g0=%b y=%h required 1 77", grant0, y);
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    req0 = 1'b1; req1 = 1'b1;
    tick();
    tests_run++;
    if (grant1 !== 1'b1 || y !== 8'h88) begin
      tests_failed++;
      $display("FAIL last_tie_g1 g1=%b y=%h required 1 88", grant1, y);
    end
  endtask

  task automatic test_reset_mid_burst();
    logic exp_g1;
    reset_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
    tick();
    reset_n = 1'b1; req1 = 1'b1; d0 = 8'h01; d1 = 8'h02;
    for (int i = 0; i < 3; i++) tick();
    req0 = 1'b1;
    tests_run++;
    if (grant1 !== 1'b1) begin
      tests_failed++;
      $display("FAIL midburst_setup g1=%b required 1", grant1);
    end
    reset_n = 1'b0;
    tick();
    tests_run++;
    if ({grant0, grant1, sel, valid} !== 4'b0000 || y !== 8'h00) begin
      tests_failed++;
      $display("FAIL midburst_reset g0=%b g1=%b sel=%b valid=%b y=%h required all 0",
               grant0, grant1, sel, valid, y);
    end
    reset_n = 1'b1; req0 = 1'b0; req1 = 1'b1;
    tick();
    tests_run++;
    if (grant1 !== 1'b1 || y !== 8'h02) begin
      tests_failed++;
      $display("FAIL midburst_restart g1=%b y=%h required 1 02", grant1, y);
    end
    req0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
`ifdef ARB_BURST_LIMIT_EN
      exp_g1 = (i < 3);
`else
      exp_g1 = 1'b1;
`endif
      tests_run++;
      if (grant1 !== exp_g1 || grant0 !== ~exp_g1) begin
        tests_failed++;
        $display("FAIL midburst_count cyc=%0d g1=%b g0=%b required g1=%b", i, grant1, grant0, exp_g1);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; req0 = 1'b0; req1 = 1'b0; d0 = 8'h00; d1 = 8'h00;
    test_reset();
    test_single();
    test_tie_burst();
    test_handover();
    test_last_tie();
    test_reset_mid_burst();
    @(negedge clk);
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
